// File: rtl/snd_pkt_sched.sv
// rtl/snd_pkt_sched.sv - round-robin packet scheduler from channel FIFOs onto one 16-bit link
module snd_pkt_sched #(
    parameter int          NCH       = 16,
    parameter int          TMO       = 255,
    parameter logic [15:0] IDLE_WORD = 16'h50BC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    fifo_have,
    input  logic [16*NCH-1:0] datain,
    output logic [NCH-1:0]    arb_want,
    input  logic              trig,
    output logic [15:0]       dataout,
    output logic              kchar,
    output logic [15:0]       abort_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_HDR,
        ST_BODY,
        ST_ABORT
    } state_t;

    state_t         state_q;
    logic [NCH-1:0] arb_want_q;
    logic [4:0]     ptr_q;
    logic [4:0]     gnt_q;
    logic [8:0]     len_q;
    logic [15:0]    stall_q;
    logic           trig_pend_q;
    logic [7:0]     tok_q;
    logic [15:0]    dataout_q;
    logic           kchar_q;
    logic [15:0]    abort_cnt_q;

    // Channel vectors widened to the 32-channel maximum so any grant index selects cleanly
    logic [63:0]  have_ext;
    logic [511:0] din_ext;
    logic         have_g;
    logic [15:0]  word_g;
    logic [15:0]  stall_d;
    logic         stall_hit;
    logic [15:0]  abort_cnt_d;
    logic         found;
    logic [4:0]   pick;
    logic [6:0]   scan;

    assign have_ext = 64'(fifo_have);
    assign din_ext  = 512'(datain);
    assign have_g   = have_ext[{1'b0, gnt_q}];
    assign word_g   = din_ext[{gnt_q, 4'b0000} +: 16];

    // Stall bookkeeping and the saturating error counter increment
    always_comb begin
        stall_d     = stall_q + 16'd1;
        stall_hit   = (stall_d == 16'(TMO));
        abort_cnt_d = (abort_cnt_q == 16'hFFFF) ? abort_cnt_q : abort_cnt_q + 16'd1;
    end

    // Round-robin search: first requesting channel strictly after the pointer, with wrap
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        scan  = '0;
        for (int k = 1; k <= NCH; k++) begin
            scan = 7'(ptr_q) + 7'(k);
            if (scan >= 7'(NCH)) begin
                scan = scan - 7'(NCH);
            end
            if (!found && have_ext[scan[5:0]]) begin
                found = 1'b1;
                pick  = scan[4:0];
            end
        end
    end

    // Scheduler FSM; all link outputs are registered here and default to idle commas
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            arb_want_q  <= '0;
            ptr_q       <= 5'(NCH - 1);
            gnt_q       <= '0;
            len_q       <= '0;
            stall_q     <= '0;
            trig_pend_q <= 1'b0;
            tok_q       <= '0;
            dataout_q   <= IDLE_WORD;
            kchar_q     <= 1'b1;
            abort_cnt_q <= '0;
        end else begin
            dataout_q <= IDLE_WORD;
            kchar_q   <= 1'b1;
            if (trig) begin
                trig_pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (trig_pend_q) begin
                        // Token word goes out as the FSM enters TOKEN
                        dataout_q <= {8'h1C, tok_q};
                        state_q   <= ST_TOKEN;
                    end else if (found) begin
                        arb_want_q <= NCH'(1) << pick;
                        gnt_q      <= pick;
                        stall_q    <= '0;
                        state_q    <= ST_HDR;
                    end
                end
                ST_TOKEN: begin
                    tok_q       <= tok_q + 8'd1;
                    trig_pend_q <= trig;
                    state_q     <= ST_IDLE;
                end
                ST_HDR, ST_BODY: begin
                    if (have_g) begin
                        stall_q <= '0;
                        if (state_q == ST_HDR && !word_g[15]) begin
                            // Framing error: header is swallowed, packet abandoned
                            abort_cnt_q <= abort_cnt_d;
                            arb_want_q  <= '0;
                            ptr_q       <= gnt_q;
                            state_q     <= ST_IDLE;
                        end else begin
                            dataout_q <= word_g;
                            kchar_q   <= 1'b0;
                            if (state_q == ST_HDR) begin
                                len_q <= word_g[8:0];
                                if (word_g[8:0] == 9'd0) begin
                                    arb_want_q <= '0;
                                    ptr_q      <= gnt_q;
                                    state_q    <= ST_IDLE;
                                end else begin
                                    state_q <= ST_BODY;
                                end
                            end else begin
                                len_q <= len_q - 9'd1;
                                if (len_q == 9'd1) begin
                                    arb_want_q <= '0;
                                    ptr_q      <= gnt_q;
                                    state_q    <= ST_IDLE;
                                end
                            end
                        end
                    end else if (stall_hit) begin
                        // Grant is released together with the abort word so no FIFO word is lost
                        dataout_q   <= {8'hFE, 3'b000, gnt_q};
                        abort_cnt_q <= abort_cnt_d;
                        arb_want_q  <= '0;
                        ptr_q       <= gnt_q;
                        stall_q     <= '0;
                        state_q     <= ST_ABORT;
                    end else begin
                        stall_q <= stall_d;
                    end
                end
                ST_ABORT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb_want  = arb_want_q;
    assign dataout   = dataout_q;
    assign kchar     = kchar_q;
    assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_snd_pkt_sched.sv
// tb/tb_snd_pkt_sched.sv - directed vector bench for snd_pkt_sched
module tb_snd_pkt_sched;

    localparam int          NCH = 16;
    localparam int          TMO = 8;
    localparam logic [15:0] IW  = 16'h50BC;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    fifo_have;
    logic [16*NCH-1:0] datain;
    logic [NCH-1:0]    arb_want;
    logic              trig;
    logic [15:0]       dataout;
    logic              kchar;
    logic [15:0]       abort_cnt;

    snd_pkt_sched #(.NCH(NCH), .TMO(TMO), .IDLE_WORD(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_have (fifo_have),
        .datain    (datain),
        .arb_want  (arb_want),
        .trig      (trig),
        .dataout   (dataout),
        .kchar     (kchar),
        .abort_cnt (abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [15:0] have;
        logic [15:0] w;
        logic        trig;
        logic [15:0] e_want;
        logic [15:0] e_dout;
        logic        e_k;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];
    int   n_chk;
    int   n_fail;

    task automatic add(input logic r, input logic [15:0] h, input logic [15:0] w, input logic t,
                       input logic [15:0] ew, input logic [15:0] ed, input logic ek,
                       input logic [15:0] ec);
        vec_t v;
        v.rst_n = r; v.have = h; v.w = w; v.trig = t;
        v.e_want = ew; v.e_dout = ed; v.e_k = ek; v.e_cnt = ec;
        vq.push_back(v);
    endtask

    // Header row plus len body rows for an already granted channel g
    task automatic add_pkt(input logic [15:0] have, input logic [15:0] g, input int len,
                           input logic [15:0] cnt);
        logic [15:0] hw;
        logic [15:0] bw;
        hw = 16'h8000 | 16'(len);
        add(1'b1, have, hw, 1'b0, (len == 0) ? 16'h0000 : g, hw, 1'b0, cnt);
        for (int i = 1; i <= len; i++) begin
            bw = 16'h0100 + 16'(i);
            add(1'b1, have, bw, 1'b0, (i == len) ? 16'h0000 : g, bw, 1'b0, cnt);
        end
    endtask

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        fifo_have = '0;
        datain = '0;
        trig = 1'b0;

        // Single channel packet, header 8004 plus four body words
        add(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0001, 16'h8004, 1'b0, 16'h0001, IW, 1'b1, 16'd0);
        add_pkt(16'h0001, 16'h0001, 4, 16'd0);
        add(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);

        // Channels 0 and 8 both requesting: 0, 8, 0, 8
        add(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);
        for (int p = 0; p < 4; p++) begin
            add(1'b1, 16'h0101, 16'h8004, 1'b0, (p % 2 == 0) ? 16'h0001 : 16'h0100, IW, 1'b1, 16'd0);
            add_pkt(16'h0101, (p % 2 == 0) ? 16'h0001 : 16'h0100, 4, 16'd0);
        end

        // Pointer parked at 4 by a zero-length packet, then 3 and 5 request: 5 wins
        add(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0010, 16'h8000, 1'b0, 16'h0010, IW, 1'b1, 16'd0);
        add_pkt(16'h0010, 16'h0010, 0, 16'd0);
        add(1'b1, 16'h0028, 16'h8004, 1'b0, 16'h0020, IW, 1'b1, 16'd0);

        // Two trigs inside a packet merge into one token right after the last word
        add(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0001, 16'h8002, 1'b0, 16'h0001, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0001, 16'h8002, 1'b0, 16'h0001, 16'h8002, 1'b0, 16'd0);
        add(1'b1, 16'h0001, 16'h0AAA, 1'b1, 16'h0001, 16'h0AAA, 1'b0, 16'd0);
        add(1'b1, 16'h0001, 16'h0BBB, 1'b1, 16'h0000, 16'h0BBB, 1'b0, 16'd0);
        add(1'b1, 16'h0001, 16'h8000, 1'b0, 16'h0000, 16'h1C00, 1'b1, 16'd0);
        add(1'b1, 16'h0001, 16'h8000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0001, 16'h8000, 1'b0, 16'h0001, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0001, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b0, 16'd0);
        add(1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h1C01, 1'b1, 16'd0);
        add(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);

        // Channel 2 stalls TMO cycles after two body words: abort word FE02
        add(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0004, 16'h8004, 1'b0, 16'h0004, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0004, 16'h8004, 1'b0, 16'h0004, 16'h8004, 1'b0, 16'd0);
        add(1'b1, 16'h0004, 16'h0001, 1'b0, 16'h0004, 16'h0001, 1'b0, 16'd0);
        add(1'b1, 16'h0004, 16'h0002, 1'b0, 16'h0004, 16'h0002, 1'b0, 16'd0);
        for (int s = 1; s < TMO; s++) begin
            add(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0004, IW, 1'b1, 16'd0);
        end
        add(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'hFE02, 1'b1, 16'd1);
        add(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd1);

        // A stall of TMO-1 cycles then resume completes the packet without abort
        add(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0004, 16'h8004, 1'b0, 16'h0004, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0004, 16'h8004, 1'b0, 16'h0004, 16'h8004, 1'b0, 16'd0);
        add(1'b1, 16'h0004, 16'h0001, 1'b0, 16'h0004, 16'h0001, 1'b0, 16'd0);
        add(1'b1, 16'h0004, 16'h0002, 1'b0, 16'h0004, 16'h0002, 1'b0, 16'd0);
        for (int s = 1; s < TMO; s++) begin
            add(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0004, IW, 1'b1, 16'd0);
        end
        add(1'b1, 16'h0004, 16'h0003, 1'b0, 16'h0004, 16'h0003, 1'b0, 16'd0);
        add(1'b1, 16'h0004, 16'h0004, 1'b0, 16'h0000, 16'h0004, 1'b0, 16'd0);
        add(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);

        // Framing error on channel 1, then channel 2 granted and left mid-body
        add(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0002, 16'h0123, 1'b0, 16'h0002, IW, 1'b1, 16'd0);
        add(1'b1, 16'h0002, 16'h0123, 1'b0, 16'h0000, IW, 1'b1, 16'd1);
        add(1'b1, 16'h0006, 16'h8004, 1'b0, 16'h0004, IW, 1'b1, 16'd1);
        add(1'b1, 16'h0006, 16'h8004, 1'b0, 16'h0004, 16'h8004, 1'b0, 16'd1);
        add(1'b1, 16'h0006, 16'h0001, 1'b0, 16'h0004, 16'h0001, 1'b0, 16'd1);

        foreach (vq[i]) begin
            rst_n     = vq[i].rst_n;
            fifo_have = vq[i].have;
            datain    = {NCH{vq[i].w}};
            trig      = vq[i].trig;
            @(posedge clk);
            #1;
            chk("arb_want", i, arb_want, vq[i].e_want);
            chk("dataout", i, dataout, vq[i].e_dout);
            chk("kchar", i, {15'd0, kchar}, {15'd0, vq[i].e_k});
            chk("abort_cnt", i, abort_cnt, vq[i].e_cnt);
        end

        // Asynchronous reset mid-body takes effect without a clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_want", -1, arb_want, 16'h0000);
        chk("rst_async_dout", -1, dataout, IW);
        chk("rst_async_k", -1, {15'd0, kchar}, 16'd1);
        chk("rst_async_cnt", -1, abort_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fifo_have = 16'h0006;
        datain = {NCH{16'h8004}};
        @(posedge clk);
        #1;
        chk("post_rst_grant", -1, arb_want, 16'h0002);
        chk("post_rst_dout", -1, dataout, IW);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/snd_pkt_sched.md
Name: snd_pkt_sched

Overview:
- Packet scheduler between N channel readout FIFOs and the single 16-bit link word stream toward the transceiver.
- Grants one channel at a time with round-robin fairness and forwards whole packets atomically (header + length-driven body).
- Inserts trigger tokens only at packet boundaries and idle commas otherwise.
- Aborts a granted channel that stalls mid-packet beyond a timeout.

Parameters:
- NCH, 16, number of requesting channels (1..32).
- TMO, 255, stall cycles tolerated inside a packet before abort (1..65535).
- IDLE_WORD, 16'h50BC, word sent with kchar=1 when nothing is forwarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fifo_have  in  NCH  channel i has a word on its datain slice this cycle
- datain  in  16*NCH  channel i word at [16*i +: 16]
- arb_want  out  NCH  one-hot grant / read enable, registered
- trig  in  1  single-cycle trigger pulse
- dataout  out  16  link word, registered
- kchar  out  1  dataout is a K-character word
- abort_cnt  out  16  saturating count of timeout aborts plus framing errors

Behaviour:
- Reset is asynchronous active-low. While asserted:
  - arb_want=0, dataout=IDLE_WORD, kchar=1, abort_cnt=0.
  - Round-robin pointer = NCH-1, so the first search starts at channel 0.
  - trig_pend=0, token number=0, FSM in IDLE.
- Transfer rule: a word moves in a cycle with arb_want[g]=1 and fifo_have[g]=1. It appears on dataout with kchar=0 exactly one clock later. Otherwise the next dataout is IDLE_WORD/kchar=1 unless a token or abort word is due.
- A trig pulse sets trig_pend. Further pulses while pending merge into it (no queue).
- FSM states:
  - IDLE:
    - If trig_pend: go to TOKEN.
    - Else if any fifo_have bit is set: pick the first set bit searching upward from pointer+1 with wrap. Set arb_want[g] and go to HDR. One-cycle arbitration latency.
  - TOKEN:
    - Emit dataout={8'h1C, tok[7:0]}, kchar=1.
    - tok increments and wraps 255->0. Clear trig_pend, return to IDLE.
    - A trig arriving in this same cycle re-sets trig_pend.
  - HDR: waits for the first transfer.
    - bit15=1: forward the word, load len=bits[8:0].
      - len=0: drop arb_want, pointer=g, go to IDLE.
      - len>0: go to BODY.
    - bit15=0 (framing error): discard the word (not forwarded), increment abort_cnt, drop arb_want, pointer=g, go to IDLE.
  - BODY:
    - Each transfer forwards the word and decrements len.
    - On the transfer that takes len 1->0: arb_want drops on the next clock edge, pointer=g, go to IDLE.
    - bit15 is not checked in BODY.
- Stall timer:
  - In HDR/BODY, each granted cycle without fifo_have[g] increments the stall counter. Any transfer clears it.
  - When the counter reaches TMO, go to ABORT.
- ABORT:
  - Emit dataout={8'hFE, 3'b000, g[4:0]}, kchar=1.
  - Increment abort_cnt (saturates at 16'hFFFF). arb_want=0, pointer=g, return to IDLE.
- arb_want is never multi-hot.
- The grant is never revoked mid-packet except by ABORT or reset.
- trig never preempts an open packet; it is served at the next IDLE.
- Reset mid-packet: the packet is truncated silently, with no abort word.

Test Plan:
- Single channel: fifo_have[0] with header 16'h8004 then 4 body words. Expect arb_want=1 from cycle 1 of IDLE detection; dataout shows the 5 words back-to-back, kchar=0; then IDLE_WORD, kchar=1, arb_want=0.
- Round robin: channels 0 and 8 continuously requesting, len=4. Expect alternating packets 0,8,0,8.
- Round robin: channels 3 and 5 requesting, pointer=4. Expect channel 5 to be served first.
- Trigger during a packet: trig pulses twice during channel 0 BODY. Expect exactly one token 16'h1C00 immediately after the last body word, then channel arbitration; the next trig yields 16'h1C01.
- Stall abort: TMO=8, channel 2 stalls 8 cycles after 2 of 4 body words. Expect IDLE_WORD during the stall, then 16'hFE02/kchar=1, abort_cnt=1, arb_want=0.
- Stall abort, boundary: a stall of 7 cycles then resume yields no abort.
- Framing error and reset: first word 16'h0123 on channel 1 is not forwarded; abort_cnt increments and channel 2 is granted next. Asserting rst_n=0 mid-BODY immediately gives arb_want=0, dataout=16'h50BC, kchar=1, and the first grant after release goes to the lowest requesting channel.
